// File: rtl/fft_pkg.sv
// Shared FFT definitions: default frame size, sample type, FSM state types and
// the bit-reversal helper used by the butterfly stages and the reorder buffer.
package fft_pkg;

  localparam int FFT_N = 3;
  localparam int FFT_W = 16;

  typedef struct packed {
    logic signed [FFT_W-1:0] re;
    logic signed [FFT_W-1:0] im;
  } cplx_t;

  typedef enum logic {
    W_IDLE,
    W_FILL
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DRAIN
  } rd_state_t;

  // Reverses the low n bits of k; bits at or above n come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] k, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) begin
        r = {r[30:0], k[i]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_if.sv
// Sample stream bundle between the last butterfly stage, the reorder buffer
// and whatever consumes the natural-order frames.
interface fft_reorder_if #(
  parameter int W = fft_pkg::FFT_W
);

  logic         start_ip;
  logic [W-1:0] ip_re;
  logic [W-1:0] ip_im;
  logic [W-1:0] op_re;
  logic [W-1:0] op_im;
  logic         op_valid;
  logic         start_op;

  modport master (
    output start_ip, ip_re, ip_im,
    input  op_re, op_im, op_valid, start_op
  );

  modport slave (
    input  start_ip, ip_re, ip_im,
    output op_re, op_im, op_valid, start_op
  );

endinterface

// File: rtl/fft_reorder_ram.sv
// Ping-pong sample store for the reorder buffer: two banks of 2^N complex
// entries addressed as {bank, index}, one write port and one synchronous read
// port with a single cycle of read latency. Contents are never reset.
module fft_reorder_ram #(
  parameter int N = 3,
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           wr_en,
  input  logic           wr_bank,
  input  logic [N-1:0]   wr_addr,
  input  logic [2*W-1:0] wr_data,
  input  logic           rd_en,
  input  logic           rd_bank,
  input  logic [N-1:0]   rd_addr,
  output logic [2*W-1:0] rd_data
);

  localparam int DEPTH = 2 * (1 << N);

  logic [2*W-1:0] mem [DEPTH];

  // Store one packed {re, im} sample into the selected bank.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  // Registered read; the data register holds when no read is requested.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[{rd_bank, rd_addr}];
    end
  end

endmodule

// File: rtl/fft_reorder.sv
// Bit-reversed to natural-order reorder buffer for a 2^N point FFT.
// Input index k is written to address bitrev(k) of the write bank; once the
// frame is complete the bank is handed to the read side, which streams
// addresses 0..2^N-1 while the next frame fills the other bank.
// Optional build macro FFT_REORDER_SCALE_EN: output components are
// arithmetic-shifted right by N (1/2^N normalisation, rounding toward -inf).
module fft_reorder
  import fft_pkg::*;
#(
  parameter int N = FFT_N,
  parameter int W = FFT_W
) (
  input logic          clk,
  input logic          rst_n,
  fft_reorder_if.slave bus
);

  localparam logic [N-1:0] LAST = '1;
  localparam logic [N-1:0] ONE  = N'(1);

  wr_state_t w_state, w_next;
  rd_state_t r_state, r_next;

  logic [N-1:0]   wcnt;
  logic [N-1:0]   rcnt;
  logic           wr_bank;
  logic           rd_bank;

  logic           wr_en;
  logic [N-1:0]   wr_k;
  logic [N-1:0]   wr_addr;
  logic           handoff;

  logic           rd_en;
  logic           rd_first;
  logic           rd_sel;
  logic [N-1:0]   rd_addr;
  logic [2*W-1:0] rd_data;

  logic           valid_q;
  logic           first_q;

  logic signed [W-1:0] rd_re;
  logic signed [W-1:0] rd_im;
  logic signed [W-1:0] out_re;
  logic signed [W-1:0] out_im;

  // Write FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
    end else begin
      w_state <= w_next;
    end
  end

  // Write FSM next state: a start always (re)enters fill, the last sample leaves it.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: begin
        if (bus.start_ip) begin
          w_next = W_FILL;
        end
      end
      W_FILL: begin
        if (!bus.start_ip && (wcnt == LAST)) begin
          w_next = W_IDLE;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write FSM outputs: a start writes index 0 in its own cycle, and the cycle
  // that writes the last index of an uninterrupted frame is the handoff.
  always_comb begin
    wr_en   = 1'b0;
    wr_k    = wcnt;
    handoff = 1'b0;
    if (bus.start_ip) begin
      wr_en = 1'b1;
      wr_k  = '0;
    end else if (w_state == W_FILL) begin
      wr_en   = 1'b1;
      handoff = (wcnt == LAST);
    end
  end

  assign wr_addr = N'(bitrev(32'(wr_k), N));

  // Write index counter and bank swap; a restart keeps the current bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      if (bus.start_ip) begin
        wcnt <= ONE;
      end else if (w_state == W_FILL) begin
        wcnt <= wcnt + ONE;
      end
      if (handoff) begin
        wr_bank <= ~wr_bank;
        rd_bank <= wr_bank;
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= r_next;
    end
  end

  // Read FSM next state: a handoff (re)starts the drain, the last address ends it.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: begin
        if (handoff) begin
          r_next = R_DRAIN;
        end
      end
      R_DRAIN: begin
        if (handoff) begin
          r_next = R_DRAIN;
        end else if (rcnt == LAST) begin
          r_next = R_IDLE;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read FSM outputs: address 0 is fetched in the handoff cycle itself from the
  // bank just completed, so the registered output lands one cycle after the
  // RAM read; the drain then walks addresses 1..2^N-1 of the read bank.
  always_comb begin
    rd_en    = 1'b0;
    rd_first = 1'b0;
    rd_addr  = rcnt;
    rd_sel   = rd_bank;
    if (handoff) begin
      rd_en    = 1'b1;
      rd_first = 1'b1;
      rd_addr  = '0;
      rd_sel   = wr_bank;
    end else if (r_state == R_DRAIN) begin
      rd_en = 1'b1;
    end
  end

  // Read address counter; it wraps back to 0 as the drain finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt <= '0;
    end else if (handoff) begin
      rcnt <= ONE;
    end else if (r_state == R_DRAIN) begin
      rcnt <= rcnt + ONE;
    end
  end

  fft_reorder_ram #(
    .N (N),
    .W (W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_data ({bus.ip_re, bus.ip_im}),
    .rd_en   (rd_en),
    .rd_bank (rd_sel),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Track which RAM read data is meaningful and which one is natural index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      valid_q <= rd_en;
      first_q <= rd_first;
    end
  end

  assign rd_re = rd_data[2*W-1:W];
  assign rd_im = rd_data[W-1:0];

`ifdef FFT_REORDER_SCALE_EN
  assign out_re = rd_re >>> N;
  assign out_im = rd_im >>> N;
`else
  assign out_re = rd_re;
  assign out_im = rd_im;
`endif

  // Output register; the sample holds its last value whenever no frame is streaming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.op_re    <= '0;
      bus.op_im    <= '0;
      bus.op_valid <= 1'b0;
      bus.start_op <= 1'b0;
    end else begin
      bus.op_valid <= valid_q;
      bus.start_op <= first_q;
      if (valid_q) begin
        bus.op_re <= out_re;
        bus.op_im <= out_im;
      end
    end
  end

endmodule

// File: tb/tb_fft_reorder.sv
// Scoreboard bench for fft_reorder (N=3, W=16). Each frame driven pushes its
// natural-order samples, with the cycle they must appear in, onto a queue;
// each scenario task then walks the recorded outputs and pops/compares.
// Build with FFT_REORDER_SCALE_EN defined to check the normalised variant.
module tb_fft_reorder;
  import fft_pkg::*;

  localparam int N     = 3;
  localparam int W     = 16;
  localparam int FRAME = 1 << N;

  typedef int frame_t [FRAME];

  typedef struct {
    int           cyc;
    logic         vld;
    logic         sop;
    logic [W-1:0] re;
    logic [W-1:0] im;
  } obs_t;

  typedef struct {
    int    cyc;
    cplx_t d;
    logic  sop;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  obs_t obs_q[$];
  exp_t exp_q[$];
  int   cur_cyc     = 0;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fft_reorder_if #(.W(W)) bus ();

  fft_reorder #(
    .N (N),
    .W (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Natural index j is fed by input index whose N-bit reversal equals j.
  function automatic int rev_idx(input int k);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) begin
      r = (r << 1) | ((k >> i) & 1);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] model_val(input int v);
`ifdef FFT_REORDER_SCALE_EN
    return W'(v >>> N);
`else
    return W'(v);
`endif
  endfunction

  // One clock: record the outputs of the cycle just begun, then drive its inputs.
  task automatic tick(input logic s, input int re, input int im);
    obs_t o;
    @(posedge clk);
    #1;
    cur_cyc++;
    o.cyc = cur_cyc;
    o.vld = bus.op_valid;
    o.sop = bus.start_op;
    o.re  = bus.op_re;
    o.im  = bus.op_im;
    obs_q.push_back(o);
    bus.start_ip = s;
    bus.ip_re    = W'(re);
    bus.ip_im    = W'(im);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 0, 0);
    end
  endtask

  // Drive len samples starting with a start pulse; a full frame with push set
  // schedules its natural-order outputs at t0+2^N+1+j.
  task automatic drive_frame(input frame_t re_v, input frame_t im_v, input int len, input bit push);
    int   t0;
    exp_t e;
    t0 = 0;
    for (int k = 0; k < len; k++) begin
      tick(k == 0, re_v[k], im_v[k]);
      if (k == 0) begin
        t0 = cur_cyc;
      end
    end
    if (push) begin
      for (int j = 0; j < FRAME; j++) begin
        e.cyc  = t0 + FRAME + 1 + j;
        e.d.re = model_val(re_v[rev_idx(j)]);
        e.d.im = model_val(im_v[rev_idx(j)]);
        e.sop  = (j == 0);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    bus.start_ip = 1'b0;
    bus.ip_re    = '0;
    bus.ip_im    = '0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors += 4;
    if (bus.op_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_op_valid: got %b, expected 0", bus.op_valid);
    end
    if (bus.start_op !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_start_op: got %b, expected 0", bus.start_op);
    end
    if (bus.op_re !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_op_re: got %h, expected 0", bus.op_re);
    end
    if (bus.op_im !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_op_im: got %h, expected 0", bus.op_im);
    end
    rst_n = 1'b1;
    idle(4);
    obs_q.delete();
  endtask

  task automatic test_single_frame();
    frame_t re_v, im_v;
    obs_t   o;
    exp_t   e;
    for (int k = 0; k < FRAME; k++) begin
      re_v[k] = k;
      im_v[k] = 0;
    end
    drive_frame(re_v, im_v, FRAME, 1'b1);
    idle(20);
    vectors += 2;
    if (bus.op_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_op_valid: got %b, expected 0", bus.op_valid);
    end
    if (bus.op_re !== model_val(7)) begin
      miscompares++;
      $display("[TB] FAIL idle_hold_op_re: got %0d, expected %0d", $signed(bus.op_re), $signed(model_val(7)));
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (o.vld || o.sop) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL single_frame_extra: cycle %0d vld=%b sop=%b re=%0d, expected no output", o.cyc, o.vld, o.sop, $signed(o.re));
        end else begin
          e = exp_q.pop_front();
          if (o.cyc !== e.cyc || o.vld !== 1'b1 || o.sop !== e.sop || o.re !== e.d.re || o.im !== e.d.im) begin
            miscompares++;
            $display("[TB] FAIL single_frame: got cyc=%0d sop=%b re=%0d im=%0d, expected cyc=%0d sop=%b re=%0d im=%0d",
                     o.cyc, o.sop, $signed(o.re), $signed(o.im), e.cyc, e.sop, $signed(e.d.re), $signed(e.d.im));
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL single_frame_missing: got %0d samples short, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    frame_t re_a, re_b, im_v;
    obs_t   o;
    exp_t   e;
    for (int k = 0; k < FRAME; k++) begin
      re_a[k] = k;
      re_b[k] = 8 + k;
      im_v[k] = 0;
    end
    drive_frame(re_a, im_v, FRAME, 1'b1);
    drive_frame(re_b, im_v, FRAME, 1'b1);
    idle(20);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (o.vld || o.sop) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL back_to_back_extra: cycle %0d vld=%b sop=%b re=%0d, expected no output", o.cyc, o.vld, o.sop, $signed(o.re));
        end else begin
          e = exp_q.pop_front();
          if (o.cyc !== e.cyc || o.vld !== 1'b1 || o.sop !== e.sop || o.re !== e.d.re || o.im !== e.d.im) begin
            miscompares++;
            $display("[TB] FAIL back_to_back: got cyc=%0d sop=%b re=%0d im=%0d, expected cyc=%0d sop=%b re=%0d im=%0d",
                     o.cyc, o.sop, $signed(o.re), $signed(o.im), e.cyc, e.sop, $signed(e.d.re), $signed(e.d.im));
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL back_to_back_missing: got %0d samples short, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_restart();
    frame_t re_p, re_v, im_v;
    obs_t   o;
    exp_t   e;
    for (int k = 0; k < FRAME; k++) begin
      re_p[k] = 100 + k;
      re_v[k] = 20 + k;
      im_v[k] = 0;
    end
    drive_frame(re_p, im_v, 5, 1'b0);
    drive_frame(re_v, im_v, FRAME, 1'b1);
    idle(20);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (o.vld || o.sop) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL restart_extra: cycle %0d vld=%b sop=%b re=%0d, expected no output", o.cyc, o.vld, o.sop, $signed(o.re));
        end else begin
          e = exp_q.pop_front();
          if (o.cyc !== e.cyc || o.vld !== 1'b1 || o.sop !== e.sop || o.re !== e.d.re || o.im !== e.d.im) begin
            miscompares++;
            $display("[TB] FAIL restart: got cyc=%0d sop=%b re=%0d im=%0d, expected cyc=%0d sop=%b re=%0d im=%0d",
                     o.cyc, o.sop, $signed(o.re), $signed(o.im), e.cyc, e.sop, $signed(e.d.re), $signed(e.d.im));
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL restart_missing: got %0d samples short, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_drain();
    frame_t re_v, im_v, re_r, im_r;
    obs_t   o;
    exp_t   e;
    for (int k = 0; k < FRAME; k++) begin
      re_v[k] = 30 + k;
      im_v[k] = -k;
      re_r[k] = int'($urandom_range(0, 65535)) - 32768;
      im_r[k] = int'($urandom_range(0, 65535)) - 32768;
    end
    drive_frame(re_v, im_v, FRAME, 1'b1);
    idle(3);
    rst_n = 1'b0;
    #1;
    vectors += 4;
    if (bus.op_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL drain_reset_op_valid: got %b, expected 0", bus.op_valid);
    end
    if (bus.start_op !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL drain_reset_start_op: got %b, expected 0", bus.start_op);
    end
    if (bus.op_re !== '0) begin
      miscompares++;
      $display("[TB] FAIL drain_reset_op_re: got %h, expected 0", bus.op_re);
    end
    if (bus.op_im !== '0) begin
      miscompares++;
      $display("[TB] FAIL drain_reset_op_im: got %h, expected 0", bus.op_im);
    end
    while (exp_q.size() > 2) begin
      void'(exp_q.pop_back());
    end
    idle(2);
    rst_n = 1'b1;
    idle(25);
    drive_frame(re_r, im_r, FRAME, 1'b1);
    idle(20);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (o.vld || o.sop) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL reset_drain_extra: cycle %0d vld=%b sop=%b re=%0d, expected no output", o.cyc, o.vld, o.sop, $signed(o.re));
        end else begin
          e = exp_q.pop_front();
          if (o.cyc !== e.cyc || o.vld !== 1'b1 || o.sop !== e.sop || o.re !== e.d.re || o.im !== e.d.im) begin
            miscompares++;
            $display("[TB] FAIL reset_drain: got cyc=%0d sop=%b re=%0d im=%0d, expected cyc=%0d sop=%b re=%0d im=%0d",
                     o.cyc, o.sop, $signed(o.re), $signed(o.im), e.cyc, e.sop, $signed(e.d.re), $signed(e.d.im));
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL reset_drain_missing: got %0d samples short, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_scale_values();
    frame_t re_v, im_v, re_a, im_a, re_b, im_b;
    obs_t   o;
    exp_t   e;
    re_v = '{-8, 16, -24, 32, 40, -48, 56, -9};
    for (int k = 0; k < FRAME; k++) begin
      im_v[k] = 8;
      re_a[k] = int'($urandom_range(0, 65535)) - 32768;
      im_a[k] = int'($urandom_range(0, 65535)) - 32768;
      re_b[k] = int'($urandom_range(0, 65535)) - 32768;
      im_b[k] = int'($urandom_range(0, 65535)) - 32768;
    end
    drive_frame(re_v, im_v, FRAME, 1'b1);
    drive_frame(re_a, im_a, FRAME, 1'b1);
    idle(int'($urandom_range(1, 5)));
    drive_frame(re_b, im_b, FRAME, 1'b1);
    idle(20);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (o.vld || o.sop) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL values_extra: cycle %0d vld=%b sop=%b re=%0d, expected no output", o.cyc, o.vld, o.sop, $signed(o.re));
        end else begin
          e = exp_q.pop_front();
          if (o.cyc !== e.cyc || o.vld !== 1'b1 || o.sop !== e.sop || o.re !== e.d.re || o.im !== e.d.im) begin
            miscompares++;
            $display("[TB] FAIL values: got cyc=%0d sop=%b re=%0d im=%0d, expected cyc=%0d sop=%b re=%0d im=%0d",
                     o.cyc, o.sop, $signed(o.re), $signed(o.im), e.cyc, e.sop, $signed(e.d.re), $signed(e.d.im));
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL values_missing: got %0d samples short, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_restart();
    test_reset_drain();
    test_scale_values();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_reorder.md
FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 SHALL have parameter N, default 3, log2 of the FFT frame length (frame = 2^N samples).
REQ-002 SHALL have parameter W, default 16, two's-complement width of each real and imaginary component.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_ip  input  1  one-cycle pulse marking sample 0 of a bit-reversed frame from the last butterfly stage.
REQ-006 SHALL have ports ip_re, ip_im  input  W each  the incoming sample, one per cycle.
REQ-007 SHALL have ports op_re, op_im  output  W each  the natural-order output sample, registered.
REQ-008 SHALL have port op_valid  output  1  high while op_re/op_im carry a frame sample.
REQ-009 SHALL have port start_op  output  1  one-cycle pulse coincident with natural-order sample 0.

Function
REQ-010 SHALL accept one sample per cycle for 2^N consecutive cycles, starting in the cycle where start_ip is high (input index k = 0..2^N-1).
REQ-011 SHALL write input index k to address bitrev_N(k) of the current write bank.
REQ-012 SHALL use two banks of 2^N complex entries (ping-pong); a completed frame's bank becomes the read bank, and the other bank becomes the write bank.
REQ-013 SHALL implement the write FSM with states W_IDLE and W_FILL:
  - W_IDLE -> W_FILL on start_ip.
  - W_FILL -> W_IDLE after k = 2^N-1 is written, with a handoff to read.
REQ-014 SHALL implement the read FSM with states R_IDLE and R_DRAIN; on handoff it reads addresses 0..2^N-1 in natural order, one per cycle.
REQ-015 SHALL have a fixed latency: with start_ip in cycle t0, start_op and op_valid are high in cycle t0+2^N+1, and natural index j appears in cycle t0+2^N+1+j.
REQ-016 SHALL support back-to-back frames (start_ip every 2^N cycles) with continuous op_valid and no gaps or stalls.
REQ-017 SHALL, on start_ip while in W_FILL (mid-frame), discard the partial frame, restart at k=0 in the same bank, and produce no output for the discarded frame.
REQ-018 SHALL, on start_ip while R_DRAIN is active, write the new frame into the opposite bank without disturbing the ongoing readout.
REQ-019 SHALL, when R_DRAIN ends in the same cycle a new handoff occurs, begin the next readout immediately, with start_op re-pulsed for it.
REQ-020 SHALL hold op_re/op_im at their last value and op_valid=0 while idle; start_op is never high for more than one cycle per frame.
REQ-021 SHALL wrap the counters naturally at 2^N; N-bit counters are sufficient.

Reset
REQ-022 SHALL, while rst_n=0, force op_re, op_im, op_valid and start_op to 0, both FSMs to idle, counters to 0, and bank select to 0.
REQ-023 SHALL NOT reset RAM contents.
REQ-024 SHALL, on reset during fill or drain, abandon the frame; after release, no output appears until a new start_ip completes a full frame.

Configuration
REQ-025 SHALL, when macro FFT_REORDER_SCALE_EN is defined, output each component arithmetic-shifted right by N (1/2^N normalization, truncation toward negative infinity).
REQ-026 SHALL, when FFT_REORDER_SCALE_EN is undefined, output stored values unmodified.
REQ-027 SHALL NOT change latency or handshake timing in either configuration.

Structure
REQ-028 SHALL take the complex sample typedef (re/im, W bits), default N, and a bitrev function from a shared package fft_pkg, also used by the butterfly stages.
REQ-029 SHALL place storage in a sub-module fft_reorder_ram: two banks, one write port and one synchronous read port, 1-cycle read latency.

Verification
REQ-030 SHALL cover: N=3, start_ip at t0, ip_re=0..7, ip_im=0 -> op_re=0,4,2,6,1,5,3,7 in cycles t0+9..t0+16, start_op only at t0+9.
REQ-031 SHALL cover: two frames back-to-back (second ip_re=8..15) -> 16 continuous valid cycles, second frame 8,12,10,14,9,13,11,15, start_op at t0+9 and t0+17.
REQ-032 SHALL cover: start_ip reissued at k=5, then a full frame of ip_re=20..27 -> only 20,24,22,26,21,25,23,27 output, with start_op at restart+9.
REQ-033 SHALL cover: rst_n pulsed low at t0+10 during drain -> all outputs 0 immediately, no further op_valid until a new frame.
REQ-034 SHALL cover: FFT_REORDER_SCALE_EN defined, ip_re=-8,16,…, ip_im=8 -> op_re=-1,2,…, op_im=1 with timing identical to REQ-030.
